// File: rtl/irq_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : irq_dispatch
// Brief    : SM83 interrupt dispatch sequencer (IME control, 5 M-cycle entry).
//            Optional macro IRQ_DISPATCH_CANCEL_EN moves winner selection to
//            the end of the high-byte push (late cancel / re-prioritise).
// Revision : 1.0
// ============================================================================
module irq_dispatch #(
    parameter int         MCYC     = 4,
    parameter logic [7:0] VEC_BASE = 8'h40
) (
    input  logic       CLK,
    input  logic       nRES,
    input  logic [7:0] CPU_IRQ_TRIG,
    input  logic [7:0] IE,
    input  logic       EI_EXEC,
    input  logic       DI_EXEC,
    input  logic       RETI_EXEC,
    input  logic       INSTR_END,
    input  logic       DISP_GO,
    output logic       DISP_REQ,
    output logic       BUSY,
    output logic       STK_WR_H,
    output logic       STK_WR_L,
    output logic       PC_LOAD,
    output logic [7:0] VEC,
    output logic [7:0] CPU_IRQ_ACK,
    output logic       IME,
    output logic       HALT_WAKE
);

    localparam int             TCW       = (MCYC > 2) ? $clog2(MCYC) : 1;
    localparam logic [TCW-1:0] c_tc_last = TCW'(MCYC - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_W1     = 3'd1,
        S_W2     = 3'd2,
        S_PUSH_H = 3'd3,
        S_PUSH_L = 3'd4,
        S_JUMP   = 3'd5
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [TCW-1:0] r_tc;
    logic           r_ime;
    logic           r_ei_pend;
    logic           r_ei_armed;
    logic [7:0]     r_vec;
    logic [7:0]     r_ack;

    logic [7:0]     w_pend;
    logic [7:0]     w_win_onehot;
    logic [7:0]     w_win_vec;
    logic [2:0]     w_win_idx;
    logic           w_idle;
    logic           w_mc_end;
    logic           w_enter;
    logic           w_stk_wr_h;
    logic           w_stk_wr_l;
    logic           w_pc_load;

    assign w_pend       = CPU_IRQ_TRIG & IE;
    // Two's-complement trick isolates the lowest set bit (highest priority).
    assign w_win_onehot = w_pend & (~w_pend + 8'd1);

    always_comb begin
        w_win_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_pend[i]) begin
                w_win_idx = 3'(i);
            end
        end
    end

    assign w_win_vec = VEC_BASE + {2'b00, w_win_idx, 3'b000};
    assign w_idle    = (r_state == S_IDLE);
    assign w_mc_end  = (r_tc == c_tc_last);
    assign w_enter   = w_idle & DISP_GO & r_ime & (|w_pend);

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            r_state <= S_IDLE;
            r_tc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_idle || w_mc_end) begin
                r_tc <= '0;
            end else begin
                r_tc <= r_tc + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stk_wr_h  = 1'b0;
        w_stk_wr_l  = 1'b0;
        w_pc_load   = 1'b0;
        case (r_state)
            S_IDLE:   if (w_enter)  w_state_nxt = S_W1;
            S_W1:     if (w_mc_end) w_state_nxt = S_W2;
            S_W2:     if (w_mc_end) w_state_nxt = S_PUSH_H;
            S_PUSH_H: begin
                w_stk_wr_h = w_mc_end;
                if (w_mc_end) w_state_nxt = S_PUSH_L;
            end
            S_PUSH_L: begin
                w_stk_wr_l = w_mc_end;
                if (w_mc_end) w_state_nxt = S_JUMP;
            end
            S_JUMP: begin
                w_pc_load = w_mc_end;
                if (w_mc_end) w_state_nxt = S_IDLE;
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Winner selection: ACK and VEC are captured on the same edge.
    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            r_vec <= 8'h00;
            r_ack <= 8'h00;
        end else begin
            r_ack <= 8'h00;
`ifdef IRQ_DISPATCH_CANCEL_EN
            if (r_state == S_PUSH_H && w_mc_end) begin
                r_ack <= w_win_onehot;
                r_vec <= (|w_pend) ? w_win_vec : 8'h00;
            end
`else
            if (w_enter) begin
                r_ack <= w_win_onehot;
                r_vec <= w_win_vec;
            end
`endif
        end
    end

    // EI takes effect at the end of the instruction following EI: pend -> armed -> IME.
    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            r_ime      <= 1'b0;
            r_ei_pend  <= 1'b0;
            r_ei_armed <= 1'b0;
        end else if (w_enter) begin
            r_ime      <= 1'b0;
            r_ei_pend  <= 1'b0;
            r_ei_armed <= 1'b0;
        end else if (w_idle) begin
            if (DI_EXEC) begin
                r_ime      <= 1'b0;
                r_ei_pend  <= 1'b0;
                r_ei_armed <= 1'b0;
            end else begin
                if (RETI_EXEC) begin
                    r_ime <= 1'b1;
                end
                if (INSTR_END && r_ei_armed) begin
                    r_ime      <= 1'b1;
                    r_ei_armed <= 1'b0;
                    r_ei_pend  <= 1'b0;
                end else if (INSTR_END && (r_ei_pend || EI_EXEC)) begin
                    r_ei_armed <= 1'b1;
                    r_ei_pend  <= 1'b0;
                end else if (EI_EXEC) begin
                    r_ei_pend <= 1'b1;
                end
            end
        end
    end

    assign DISP_REQ    = r_ime & (|w_pend) & w_idle;
    assign BUSY        = ~w_idle;
    assign STK_WR_H    = w_stk_wr_h;
    assign STK_WR_L    = w_stk_wr_l;
    assign PC_LOAD     = w_pc_load;
    assign VEC         = r_vec;
    assign CPU_IRQ_ACK = r_ack;
    assign IME         = r_ime;
    assign HALT_WAKE   = |w_pend;

endmodule
`default_nettype wire
